// File: rtl/fnm_product_resolve.sv
// FNMADD product resolve: 2-stage split CPA on the multiplier's carry-save pair,
// then negate/extend/magnitude. Define FNM_PRODUCT_LZC_EN to add the lzc_o output.
module fnm_product_resolve #(
   parameter int IN_WIDTH   = 18,
   parameter int PROD_WIDTH = 16,
   parameter int LZC_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [IN_WIDTH-1:0]   sum_i,
   input  logic [IN_WIDTH-1:0]   carry_i,
   input  logic                  tc_i,
   input  logic                  neg_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [PROD_WIDTH:0]   res_o,
   output logic                  sign_o,
   output logic [PROD_WIDTH-1:0] mag_o
`ifdef FNM_PRODUCT_LZC_EN
   ,
   output logic [LZC_WIDTH-1:0]  lzc_o
`endif
);

   localparam int H = PROD_WIDTH / 2;
   localparam int U = PROD_WIDTH - H;
   localparam logic [PROD_WIDTH:0] ONE = 1;

   logic s2_adv, in_rdy, accept;
   logic c1_n;
   logic [H-1:0] lo_n;

   logic s1_valid_q, s1_valid_d;
   logic [H-1:0] s1_lo_q, s1_lo_d;
   logic s1_c1_q, s1_c1_d;
   logic [U-1:0] s1_ah_q, s1_ah_d;
   logic [U-1:0] s1_bh_q, s1_bh_d;
   logic s1_tc_q, s1_tc_d;
   logic s1_neg_q, s1_neg_d;

   logic [U-1:0] hi_n;
   logic [PROD_WIDTH-1:0] prod_n;
   logic [PROD_WIDTH:0] ext_n, res_n, mag_full_n;
   logic [PROD_WIDTH-1:0] mag_n;

   logic out_valid_q, out_valid_d;
   logic [PROD_WIDTH:0] res_q, res_d;
   logic [PROD_WIDTH-1:0] mag_q, mag_d;

   logic unused_hi;
   assign unused_hi = ^{sum_i[IN_WIDTH-1:PROD_WIDTH],
                        carry_i[IN_WIDTH-1:PROD_WIDTH]};

   always_comb begin
      s2_adv = !out_valid_q | out_ready_i;
      in_rdy = !s1_valid_q | s2_adv;
      accept = in_valid_i & in_rdy;

      {c1_n, lo_n} = {1'b0, sum_i[H-1:0]} + {1'b0, carry_i[H-1:0]};

      s1_valid_d = s1_valid_q;
      s1_lo_d    = s1_lo_q;
      s1_c1_d    = s1_c1_q;
      s1_ah_d    = s1_ah_q;
      s1_bh_d    = s1_bh_q;
      s1_tc_d    = s1_tc_q;
      s1_neg_d   = s1_neg_q;
      if (in_rdy) s1_valid_d = in_valid_i;
      if (accept) begin
         s1_lo_d  = lo_n;
         s1_c1_d  = c1_n;
         s1_ah_d  = sum_i[PROD_WIDTH-1:H];
         s1_bh_d  = carry_i[PROD_WIDTH-1:H];
         s1_tc_d  = tc_i;
         s1_neg_d = neg_i;
      end
   end

   // Stage 2: finish the carry chain, then extend/negate/abs.
   always_comb begin
      hi_n   = s1_ah_q + s1_bh_q + U'(s1_c1_q);
      prod_n = {hi_n, s1_lo_q};
      ext_n  = s1_tc_q ? {prod_n[PROD_WIDTH-1], prod_n}
                       : {1'b0, prod_n};
      res_n  = s1_neg_q ? (~ext_n + ONE) : ext_n;
      mag_full_n = res_n[PROD_WIDTH] ? (~res_n + ONE) : res_n;
      mag_n  = mag_full_n[PROD_WIDTH-1:0];

      out_valid_d = out_valid_q;
      res_d       = res_q;
      mag_d       = mag_q;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            res_d = res_n;
            mag_d = mag_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_lo_q     <= '0;
         s1_c1_q     <= 1'b0;
         s1_ah_q     <= '0;
         s1_bh_q     <= '0;
         s1_tc_q     <= 1'b0;
         s1_neg_q    <= 1'b0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         mag_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_lo_q     <= s1_lo_d;
         s1_c1_q     <= s1_c1_d;
         s1_ah_q     <= s1_ah_d;
         s1_bh_q     <= s1_bh_d;
         s1_tc_q     <= s1_tc_d;
         s1_neg_q    <= s1_neg_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         mag_q       <= mag_d;
      end
   end

`ifdef FNM_PRODUCT_LZC_EN
   logic [LZC_WIDTH-1:0] lzc_n, lzc_q, lzc_d;

   // Upward scan: the highest set bit is the last one to write lzc_n.
   always_comb begin
      lzc_n = LZC_WIDTH'(PROD_WIDTH);
      for (int i = 0; i < PROD_WIDTH; i++) begin
         if (mag_n[i]) lzc_n = LZC_WIDTH'(PROD_WIDTH - 1 - i);
      end
      lzc_d = lzc_q;
      if (s2_adv && s1_valid_q) lzc_d = lzc_n;
   end

   always_ff @(posedge clk) begin
      if (rst) lzc_q <= '0;
      else     lzc_q <= lzc_d;
   end

   assign lzc_o = lzc_q;
`endif

   assign in_ready_o  = in_rdy;
   assign out_valid_o = out_valid_q;
   assign res_o       = res_q;
   assign sign_o      = res_q[PROD_WIDTH];
   assign mag_o       = mag_q;

endmodule

// File: doc/fnm_product_resolve.md
Name: fnm_product_resolve

Overview:
- Sits directly downstream of the Booth/Wallace multiplier in the FNMADD mantissa path.
- Takes the multiplier's carry-save pair (sum vector, carry vector) and resolves it with a 2-stage split carry-propagate adder.
- Applies FNMADD product negation and emits signed result, sign, magnitude and, optionally, leading-zero count to the aligner/adder.
- Valid/ready handshake on both sides; full-throughput pipeline.

Parameters:
- IN_WIDTH, 18, width of each carry-save input vector (the multiplier's out_width).
- PROD_WIDTH, 16, significant product width (a_width+b_width); must be even and <= IN_WIDTH-2.
- LZC_WIDTH, 5, width of lzc_o; must satisfy 2^LZC_WIDTH > PROD_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid_i  input  1  carry-save pair and sidebands valid.
- in_ready_o  output  1  stage 1 can accept this cycle.
- sum_i  input  IN_WIDTH  carry-save vector 0.
- carry_i  input  IN_WIDTH  carry-save vector 1.
- tc_i  input  1  1 = signed product, 0 = unsigned.
- neg_i  input  1  1 = negate product (FNMADD).
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts.
- res_o  output  PROD_WIDTH+1  signed result, two's complement.
- sign_o  output  1  res_o MSB.
- mag_o  output  PROD_WIDTH  absolute value of res_o.
- lzc_o  output  LZC_WIDTH  leading zeros of mag_o (only with the macro).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All stage valids clear on reset; res_o, sign_o, mag_o and lzc_o reset to 0.
- Arithmetic:
  - P = (sum_i + carry_i) mod 2^IN_WIDTH; prod = P[PROD_WIDTH-1:0]; bits above PROD_WIDTH are discarded.
  - ext = tc ? sign-extend(prod) : zero-extend(prod), to PROD_WIDTH+1 bits.
  - res = neg ? (~ext + 1) : ext, mod 2^(PROD_WIDTH+1).
  - sign_o = res[PROD_WIDTH]; mag_o = sign_o ? -res : res, truncated to PROD_WIDTH bits.
  - A zero product yields res = 0 and sign_o = 0 regardless of neg.
- Stage 1, on accept:
  - Add the low H = PROD_WIDTH/2 bits and register the low sum plus carry-out c1.
  - Register upper operand bits [PROD_WIDTH-1:H], tc and neg.
- Stage 2: upper add plus c1, then extend, negate and take magnitude. Register all outputs.
- Latency: exactly 2 cycles from the accept edge to out_valid_o when no stall occurs.
- Handshake:
  - Input transfer when in_valid_i & in_ready_o. Output transfer when out_valid_o & out_ready_i.
  - s2 advances when !out_valid_o | out_ready_i. in_ready_o = !s1_valid | s2 advances.
  - Stalled stages hold their data unchanged. Outputs must stay stable while out_valid_o=1 and out_ready_i=0.
  - in_ready_o must not depend combinationally on in_valid_i.
- Throughput: one result per cycle when out_ready_i is held high.
- Capacity: with out_ready_i low, at most 2 transactions are held, then in_ready_o=0.
- Simultaneous events: accept and drain in the same cycle on a full pipe keeps occupancy at 2, with no bubble.
- Reset mid-operation: in-flight data is dropped. out_valid_o=0 and in_ready_o=1 on the first cycle after rst deasserts.
- No X-propagation masking: garbage in gives defined garbage out.

Optional Feature:
- Macro: FNM_PRODUCT_LZC_EN.
- Defined:
  - lzc_o is present and registered in stage 2 alongside mag_o.
  - lzc_o = count of leading zeros of mag_o from bit PROD_WIDTH-1; mag_o = 0 gives PROD_WIDTH.
- Undefined: the lzc_o port and its logic are absent. All other behaviour is identical.

Test Plan:
- Signed, no negate: feed the multiplier pair for a=-128, b=-128, tc=1, neg=0 -> res_o=17'h04000, sign_o=0, mag_o=16'h4000, lzc_o=1, out_valid_o exactly 2 cycles after accept.
- Signed, negate: same operands with neg=1 -> res_o=17'h1C000, sign_o=1, mag_o=16'h4000.
- Unsigned, negate: a=255, b=255, tc=0, neg=1 (product 0xFE01) -> res_o=17'h101FF, sign_o=1, mag_o=16'hFE01, lzc_o=0.
- Zero and carry wrap:
  - sum_i=18'h3FFFF, carry_i=18'h00001, neg=1 -> res_o=0, sign_o=0, mag_o=0, lzc_o=16.
  - sum_i=18'h000FF, carry_i=18'h00001 -> res_o=17'h00100, checking the low-to-high carry c1.
- Backpressure: stream 4 back-to-back products with out_ready_i=0 for 3 cycles -> in_ready_o drops after 2 accepts. After release, results emerge in order, one per cycle, with values unchanged while stalled.
- Reset mid-op: assert rst for 1 cycle with 2 transactions in flight -> out_valid_o=0 and in_ready_o=1 on the next cycle. A new transaction then completes with correct value at latency 2.
